fun_exec_arbiter: RTL and testbench

- Shares one 3-bit functionality execution unit between two requesters, A and B, each presenting a 3-bit function code.
- Uses an equality compare of the two codes to merge identical simultaneous requests into one execution.
- Differing codes are served one at a time in round-robin order.
- Sits between the user interface panels and the functionality executor. Drives the executor's code and start strobe, and returns per-requester acknowledges.

---
 rtl/fun_exec_arbiter.sv | 144 ++++++++++++++
 tb/tb_fun_exec_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fun_exec_arbiter.sv
// Two-requester arbiter for a shared 3-bit function executor.
// Identical simultaneous codes are merged into one job; differing codes alternate round-robin.
module fun_exec_arbiter #(
   parameter int unsigned EXEC_CYCLES = 4,
   parameter int unsigned CNT_W       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_a,
   input  logic [2:0] fun_a,
   input  logic       req_b,
   input  logic [2:0] fun_b,
   output logic [2:0] fun_out,
   output logic       start,
   output logic       busy,
   output logic       grant_a,
   output logic       grant_b,
   output logic       merged,
   output logic       ack_a,
   output logic       ack_b
);

   localparam int unsigned LAST_CNT = EXEC_CYCLES - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             prio, prio_d;
   logic [2:0]       fun_out_d;
   logic             start_d, busy_d, grant_a_d, grant_b_d, merged_d, ack_a_d, ack_b_d;
   logic             same_code_c, take_a_c, take_b_c;

   // Equal codes let both requesters win; otherwise prio breaks the tie (0 = A).
   assign same_code_c = &(fun_a ~^ fun_b);
   assign take_a_c    = req_a & (~req_b | same_code_c | ~prio);
   assign take_b_c    = req_b & (~req_a | same_code_c | prio);

   // State, counter, priority and all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         prio    <= 1'b0;
         fun_out <= 3'b000;
         start   <= 1'b0;
         busy    <= 1'b0;
         grant_a <= 1'b0;
         grant_b <= 1'b0;
         merged  <= 1'b0;
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         prio    <= prio_d;
         fun_out <= fun_out_d;
         start   <= start_d;
         busy    <= busy_d;
         grant_a <= grant_a_d;
         grant_b <= grant_b_d;
         merged  <= merged_d;
         ack_a   <= ack_a_d;
         ack_b   <= ack_b_d;
      end
   end

   // Next-state and execution counter.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (req_a | req_b) begin
               state_d = EXEC;
               cnt_d   = '0;
            end
         end
         EXEC: begin
            if (cnt == CNT_W'(LAST_CNT)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and the priority pointer.
   always_comb begin
      fun_out_d = fun_out;
      start_d   = 1'b0;
      busy_d    = (state_d != IDLE);
      grant_a_d = grant_a;
      grant_b_d = grant_b;
      merged_d  = merged;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;
      prio_d    = prio;
      case (state)
         IDLE: begin
            grant_a_d = take_a_c;
            grant_b_d = take_b_c;
            merged_d  = take_a_c & take_b_c;
            start_d   = req_a | req_b;
            if (take_a_c) begin
               fun_out_d = fun_a;
            end else if (take_b_c) begin
               fun_out_d = fun_b;
            end
         end
         EXEC: begin
            if (state_d == DONE) begin
               ack_a_d = grant_a;
               ack_b_d = grant_b;
            end
         end
         DONE: begin
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            merged_d  = 1'b0;
            // A merged job serves both sides and leaves the pointer alone.
            if (grant_a & ~grant_b) begin
               prio_d = 1'b1;
            end else if (grant_b & ~grant_a) begin
               prio_d = 1'b0;
            end
         end
         default: begin
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            merged_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fun_exec_arbiter.sv
// Scoreboard bench for fun_exec_arbiter: expected jobs are queued at stimulus time
// and matched against start pulses and acknowledges.
module tb_fun_exec_arbiter;

   localparam int unsigned EXEC_CYCLES = 4;
   localparam int unsigned CNT_W       = 3;

   typedef struct {
      logic [2:0] fun;
      logic       ga;
      logic       gb;
      logic       mg;
   } job_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, req_b;
   logic [2:0] fun_a, fun_b;
   logic [2:0] fun_out;
   logic       start, busy, grant_a, grant_b, merged, ack_a, ack_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_run = 0;

   job_t exp_q[$];
   job_t act_q[$];
   int   act_start[$];
   int   start_log[$];

   fun_exec_arbiter #(.EXEC_CYCLES(EXEC_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .fun_a(fun_a), .req_b(req_b), .fun_b(fun_b),
      .fun_out(fun_out), .start(start), .busy(busy),
      .grant_a(grant_a), .grant_b(grant_b), .merged(merged),
      .ack_a(ack_a), .ack_b(ack_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic job_t mk(input logic [2:0] f, input logic a, input logic b);
      job_t j;
      j.fun = f;
      j.ga  = a;
      j.gb  = b;
      j.mg  = a & b;
      return j;
   endfunction

   // Output monitor: match start pulses and acks against the scoreboard.
   always @(negedge clk) begin
      job_t j;
      int   st;
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (start) begin
            if (exp_q.size() == 0) begin
               chk("start_unexpected", 32'(1), 32'(0));
            end else begin
               j = exp_q.pop_front();
               chk("fun_out", 32'(fun_out), 32'(j.fun));
               chk("grant_a", 32'(grant_a), 32'(j.ga));
               chk("grant_b", 32'(grant_b), 32'(j.gb));
               chk("merged", 32'(merged), 32'(j.mg));
               chk("busy_at_start", 32'(busy), 32'(1));
               act_q.push_back(j);
               act_start.push_back(cyc);
               start_log.push_back(cyc);
            end
         end
         if (ack_a || ack_b) begin
            if (act_q.size() == 0) begin
               chk("ack_unexpected", 32'(1), 32'(0));
            end else begin
               j  = act_q.pop_front();
               st = act_start.pop_front();
               chk("ack_a", 32'(ack_a), 32'(j.ga));
               chk("ack_b", 32'(ack_b), 32'(j.gb));
               chk("ack_latency", 32'(cyc - st), 32'(EXEC_CYCLES));
               chk("fun_out_hold", 32'(fun_out), 32'(j.fun));
            end
         end
         if (busy) begin
            busy_run++;
         end else if (busy_run > 0) begin
            chk("busy_len", 32'(busy_run), 32'(EXEC_CYCLES + 1));
            busy_run = 0;
         end
      end
   end

   // Requester model: hold each req until its N-th ack has been seen, then drop it.
   task automatic wait_acks(input int need_a, input int need_b, input int budget);
      int got_a = 0;
      int got_b = 0;
      int n     = 0;
      while ((got_a < need_a || got_b < need_b) && n < budget) begin
         @(negedge clk);
         n++;
         if (ack_a && got_a < need_a) begin
            got_a++;
            if (got_a == need_a) req_a = 1'b0;
         end
         if (ack_b && got_b < need_b) begin
            got_b++;
            if (got_b == need_b) req_b = 1'b0;
         end
      end
      if (got_a < need_a || got_b < need_b) begin
         chk("ack_timeout", 32'(0), 32'(1));
         req_a = 1'b0;
         req_b = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic chk_gap(input string tag);
      int n = start_log.size();
      if (n < 2) chk(tag, 32'(0), 32'(1));
      else chk(tag, 32'(start_log[n-1] - start_log[n-2]), 32'(EXEC_CYCLES + 2));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fun_out"}, 32'(fun_out), 32'(0));
      chk({tag, "_start"}, 32'(start), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_grant_a"}, 32'(grant_a), 32'(0));
      chk({tag, "_grant_b"}, 32'(grant_b), 32'(0));
      chk({tag, "_merged"}, 32'(merged), 32'(0));
      chk({tag, "_ack_a"}, 32'(ack_a), 32'(0));
      chk({tag, "_ack_b"}, 32'(ack_b), 32'(0));
   endtask

   task automatic tie(input logic [2:0] fa, input logic [2:0] fb, input logic a_first);
      @(negedge clk);
      req_a = 1'b1; fun_a = fa;
      req_b = 1'b1; fun_b = fb;
      if (a_first) begin
         exp_q.push_back(mk(fa, 1'b1, 1'b0));
         exp_q.push_back(mk(fb, 1'b0, 1'b1));
      end else begin
         exp_q.push_back(mk(fb, 1'b0, 1'b1));
         exp_q.push_back(mk(fa, 1'b1, 1'b0));
      end
      wait_acks(1, 1, 40);
      chk_gap("tie_gap");
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0;
      fun_a = 3'b000; fun_b = 3'b000;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Round-robin tie from reset: A first, then B; repeat gives A first again.
      tie(3'b001, 3'b110, 1'b1);
      tie(3'b001, 3'b110, 1'b1);

      // Single A request; pointer then favours B on the next tie.
      @(negedge clk);
      req_a = 1'b1; fun_a = 3'b101;
      exp_q.push_back(mk(3'b101, 1'b1, 1'b0));
      wait_acks(1, 0, 20);
      tie(3'b010, 3'b100, 1'b0);

      // Merge of identical codes; pointer (1) untouched, so B wins the next tie.
      @(negedge clk);
      req_a = 1'b1; fun_a = 3'b011;
      req_b = 1'b1; fun_b = 3'b011;
      exp_q.push_back(mk(3'b011, 1'b1, 1'b1));
      wait_acks(1, 1, 20);
      tie(3'b111, 3'b000, 1'b0);

      // Inputs change mid-job: fun_out holds and B waits for DONE plus one IDLE.
      @(negedge clk);
      req_a = 1'b1; fun_a = 3'b010;
      exp_q.push_back(mk(3'b010, 1'b1, 1'b0));
      repeat (3) @(negedge clk);
      fun_a = 3'b111;
      req_b = 1'b1; fun_b = 3'b100;
      exp_q.push_back(mk(3'b100, 1'b0, 1'b1));
      wait_acks(1, 1, 40);
      chk_gap("late_b_gap");

      // Back-to-back A jobs with req_a held across the first ack.
      @(negedge clk);
      req_a = 1'b1; fun_a = 3'b110;
      exp_q.push_back(mk(3'b110, 1'b1, 1'b0));
      exp_q.push_back(mk(3'b110, 1'b1, 1'b0));
      wait_acks(2, 0, 40);
      chk_gap("b2b_gap");

      // Reset in the second EXEC cycle aborts the job; prio returns to A afterwards.
      @(negedge clk);
      req_a = 1'b1; fun_a = 3'b011;
      exp_q.push_back(mk(3'b011, 1'b1, 1'b0));
      n = 0;
      while (!start && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("abort_job_started", 32'(start), 32'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort");
      exp_q.delete();
      act_q.delete();
      act_start.delete();
      req_b = 1'b1; fun_b = 3'b101;
      repeat (3) @(negedge clk);
      chk_all_zero("held_reset");
      rst_n = 1'b1;
      exp_q.push_back(mk(3'b011, 1'b1, 1'b0));
      exp_q.push_back(mk(3'b101, 1'b0, 1'b1));
      wait_acks(1, 1, 40);

      repeat (3) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
      chk("act_q_drained", 32'(act_q.size()), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
